// File: rtl/sprite_ram_writer.sv
// sprite_ram_writer: double-buffered sprite memory. A producer fills the back
// bank over a valid/ready stream; the renderer reads the front bank with one
// cycle of latency. A finished load is swapped in only on a frame boundary.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no load in progress, waiting for start
// LOAD    | accepting pixels into the back bank, one per valid cycle
// PENDING | back bank complete, waiting for vsync to swap banks

module sprite_ram_writer #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              vsync,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] q,
    output logic              busy,
    output logic              pending,
    output logic              front_bank,
    output logic [ADDR_W:0]   wr_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PENDING = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;
    logic              accept;

    // Both banks live in one array indexed {bank, addr}; never cleared.
    logic [DATA_W-1:0] mem [2*DEPTH];

    // wr_ready is only ever high in LOAD, so this is the LOAD write strobe.
    assign accept = wr_valid & wr_ready;

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            wr_addr    <= '0;
            wr_count   <= '0;
            wr_ready   <= 1'b0;
            busy       <= 1'b0;
            pending    <= 1'b0;
            front_bank <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        wr_addr  <= '0;
                        wr_count <= '0;
                        wr_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        wr_count <= wr_count + 1'b1;
                        if (wr_addr == LAST_ADDR) begin
                            // Address is held at the last entry rather than wrapping.
                            state    <= PENDING;
                            wr_ready <= 1'b0;
                            busy     <= 1'b0;
                            pending  <= 1'b1;
                        end else begin
                            wr_addr <= wr_addr + 1'b1;
                        end
                    end
                end
                PENDING: begin
                    if (vsync) begin
                        front_bank <= ~front_bank;
                        pending    <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wr_ready <= 1'b0;
                    busy     <= 1'b0;
                    pending  <= 1'b0;
                end
            endcase
        end
    end

    // Back-bank write port; suppressed during reset so an abandoned load
    // cannot sneak in one more pixel on the reset edge.
    always_ff @(posedge clock) begin
        if (accept && !reset) begin
            mem[{~front_bank, wr_addr}] <= wr_data;
        end
    end

    // Front-bank registered read; bank select uses the value at the read edge,
    // so a read issued in the vsync cycle still sees the old bank.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= mem[{front_bank, address}];
        end
    end

endmodule

// File: tb/tb_sprite_ram_writer.sv
// Directed self-checking bench for sprite_ram_writer.
module tb_sprite_ram_writer;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 4;

    logic              clock;
    logic              reset;
    logic              start;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              vsync;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] q;
    logic              busy;
    logic              pending;
    logic              front_bank;
    logic [ADDR_W:0]   wr_count;

    int n_checks = 0;
    int n_pass   = 0;

    sprite_ram_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .vsync      (vsync),
        .address    (address),
        .q          (q),
        .busy       (busy),
        .pending    (pending),
        .front_bank (front_bank),
        .wr_count   (wr_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_vsync;
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] pix(input int mode, input int i);
        case (mode)
            0:       return DATA_W'(i % 16);
            1:       return 4'h3;
            2:       return 4'hA;
            default: return DATA_W'((i + 1) % 16);
        endcase
    endfunction

    // Continuous full load of the back bank with pattern 'mode'.
    task automatic load_bank(input int mode);
        int busy_cycles;
        busy_cycles = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (wr_ready !== 1'b1) $display("FAIL load_ready_rise m%0d: got %0b expected 1", mode, wr_ready);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid = 1'b1;
            wr_data  = pix(mode, i);
            if (busy === 1'b1) busy_cycles++;
            tick();
        end
        wr_valid = 1'b0;
        n_checks++;
        if (busy_cycles != DEPTH) $display("FAIL load_busy_cycles m%0d: got %0d expected %0d", mode, busy_cycles, DEPTH);
        else n_pass++;
        n_checks++;
        if (pending !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b0)
            $display("FAIL load_done_flags m%0d: got pending=%0b busy=%0b ready=%0b expected 1/0/0", mode, pending, busy, wr_ready);
        else n_pass++;
        n_checks++;
        if (wr_count !== 11'd1024) $display("FAIL load_wr_count m%0d: got %0d expected 1024", mode, wr_count);
        else n_pass++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (wr_ready !== 1'b0 || busy !== 1'b0 || pending !== 1'b0 || front_bank !== 1'b0)
            $display("FAIL reset_flags: got ready=%0b busy=%0b pending=%0b front=%0b expected 0/0/0/0", wr_ready, busy, pending, front_bank);
        else n_pass++;
        n_checks++;
        if (q !== 4'h0 || wr_count !== 11'd0) $display("FAIL reset_q_count: got q=%0h count=%0d expected 0/0", q, wr_count);
        else n_pass++;
        reset = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 4'h9;
        tick();
        tick();
        tick();
        n_checks++;
        if (wr_ready !== 1'b0 || wr_count !== 11'd0 || busy !== 1'b0)
            $display("FAIL idle_valid_ignored: got ready=%0b count=%0d busy=%0b expected 0/0/0", wr_ready, wr_count, busy);
        else n_pass++;
        wr_valid = 1'b0;
    endtask

    task automatic test_full_load;
        load_bank(0);
        tick();
        tick();
        n_checks++;
        if (pending !== 1'b1 || front_bank !== 1'b0) $display("FAIL pending_hold: got pending=%0b front=%0b expected 1/0", pending, front_bank);
        else n_pass++;
        pulse_vsync();
        n_checks++;
        if (front_bank !== 1'b1 || pending !== 1'b0) $display("FAIL swap_front: got front=%0b pending=%0b expected 1/0", front_bank, pending);
        else n_pass++;
        address = 10'd37;
        tick();
        n_checks++;
        if (q !== 4'h5) $display("FAIL read_addr37: got %0h expected 5", q);
        else n_pass++;
    endtask

    task automatic test_gapped;
        int acc;
        int bad;
        logic [DATA_W-1:0] exp_q;
        acc = 0;
        bad = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 2 * DEPTH && acc < DEPTH; c++) begin
            wr_valid = (c % 2 == 0);
            wr_data  = wr_valid ? DATA_W'((acc * 7 + 3) % 16) : ~DATA_W'((acc * 7 + 3) % 16);
            tick();
            if (wr_valid) acc++;
            if (wr_count !== (ADDR_W+1)'(acc)) bad++;
        end
        wr_valid = 1'b0;
        n_checks++;
        if (bad != 0) $display("FAIL gap_count_track: got %0d bad cycles expected 0", bad);
        else n_pass++;
        n_checks++;
        if (pending !== 1'b1 || wr_count !== 11'd1024) $display("FAIL gap_done: got pending=%0b count=%0d expected 1/1024", pending, wr_count);
        else n_pass++;
        pulse_vsync();
        n_checks++;
        if (front_bank !== 1'b0) $display("FAIL gap_swap: got front=%0b expected 0", front_bank);
        else n_pass++;
        bad = 0;
        for (int a = 0; a < DEPTH; a++) begin
            address = ADDR_W'(a);
            tick();
            exp_q = DATA_W'((a * 7 + 3) % 16);
            if (q !== exp_q) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL gap_contents: got %0d bad entries expected 0", bad);
        else n_pass++;
    endtask

    task automatic test_swap_edge;
        load_bank(2);
        pulse_vsync();
        load_bank(1);
        pulse_vsync();
        n_checks++;
        if (front_bank !== 1'b0) $display("FAIL edge_setup_front: got %0b expected 0", front_bank);
        else n_pass++;
        load_bank(2);
        address = 10'd0;
        tick();
        n_checks++;
        if (q !== 4'h3) $display("FAIL edge_pre_read: got %0h expected 3", q);
        else n_pass++;
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        n_checks++;
        if (q !== 4'h3) $display("FAIL edge_vsync_read: got %0h expected 3", q);
        else n_pass++;
        tick();
        n_checks++;
        if (q !== 4'hA) $display("FAIL edge_post_read: got %0h expected a", q);
        else n_pass++;
        n_checks++;
        if (front_bank !== 1'b1) $display("FAIL edge_front: got %0b expected 1", front_bank);
        else n_pass++;
    endtask

    task automatic test_ignored_events;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid = 1'b1;
            wr_data  = pix(3, i);
            vsync    = (i == 100) || (i == DEPTH - 1);
            start    = (i == 500);
            tick();
            vsync = 1'b0;
            start = 1'b0;
            if (i == 100) begin
                n_checks++;
                if (front_bank !== 1'b1 || busy !== 1'b1) $display("FAIL vsync_in_load: got front=%0b busy=%0b expected 1/1", front_bank, busy);
                else n_pass++;
            end
            if (i == 500) begin
                n_checks++;
                if (wr_count !== 11'd501 || busy !== 1'b1) $display("FAIL start_in_load: got count=%0d busy=%0b expected 501/1", wr_count, busy);
                else n_pass++;
            end
        end
        wr_valid = 1'b0;
        n_checks++;
        if (pending !== 1'b1 || front_bank !== 1'b1) $display("FAIL final_with_vsync: got pending=%0b front=%0b expected 1/1", pending, front_bank);
        else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (pending !== 1'b1 || busy !== 1'b0) $display("FAIL start_in_pending: got pending=%0b busy=%0b expected 1/0", pending, busy);
        else n_pass++;
        start = 1'b1;
        pulse_vsync();
        start = 1'b0;
        n_checks++;
        if (front_bank !== 1'b0 || pending !== 1'b0 || busy !== 1'b0)
            $display("FAIL start_vsync_pending: got front=%0b pending=%0b busy=%0b expected 0/0/0", front_bank, pending, busy);
        else n_pass++;
        tick();
        n_checks++;
        if (busy !== 1'b0 || wr_ready !== 1'b0) $display("FAIL start_dropped: got busy=%0b ready=%0b expected 0/0", busy, wr_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid_load;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 700; i++) begin
            wr_valid = 1'b1;
            wr_data  = 4'h7;
            tick();
        end
        n_checks++;
        if (wr_count !== 11'd700) $display("FAIL mid_count: got %0d expected 700", wr_count);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wr_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || pending !== 1'b0 || wr_ready !== 1'b0 || wr_count !== 11'd0 || front_bank !== 1'b0)
            $display("FAIL mid_reset_state: got busy=%0b pending=%0b ready=%0b count=%0d front=%0b expected 0/0/0/0/0",
                     busy, pending, wr_ready, wr_count, front_bank);
        else n_pass++;
        pulse_vsync();
        n_checks++;
        if (front_bank !== 1'b0) $display("FAIL idle_vsync_noswap: got %0b expected 0", front_bank);
        else n_pass++;
        address = 10'd10;
        tick();
        n_checks++;
        if (q !== 4'hB) $display("FAIL mid_front_read: got %0h expected b", q);
        else n_pass++;
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        vsync    = 1'b0;
        address  = '0;
        test_reset();
        test_full_load();
        test_gapped();
        test_swap_edge();
        test_ignored_events();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_ram_writer.md
# sprite_ram_writer

Double-buffered, writable sprite memory: the write-side counterpart to the sprite ROMs. A producer streams 4-bit palette indices over a valid/ready handshake into the back bank. The renderer reads the front bank through the same one-cycle-latency `address`→`q` port the sprite ROMs use. Completed loads become visible only at a frame boundary, so the image is never torn mid-frame.

## Interface
- `DEPTH`, 1024, entries per bank (32×32 sprite)
- `ADDR_W`, 10, address width; DEPTH == 2**ADDR_W
- `DATA_W`, 4, palette-index width

- `clock`  in  1  sole clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  single-cycle pulse; begins a load of the back bank at address 0
- `wr_valid`  in  1  producer has a pixel on `wr_data`
- `wr_data`  in  DATA_W  palette index
- `wr_ready`  out  1  block accepts `wr_data` this cycle
- `vsync`  in  1  single-cycle frame-boundary pulse
- `address`  in  ADDR_W  renderer read address, front bank
- `q`  out  DATA_W  registered read data, one cycle after `address`
- `busy`  out  1  high in LOAD
- `pending`  out  1  high in PENDING (load complete, awaiting `vsync`)
- `front_bank`  out  1  bank currently visible to the renderer
- `wr_count`  out  ADDR_W+1  pixels accepted in the current or most recent load

## Operation
- Storage is 2×DEPTH×DATA_W, indexed {bank, addr}. The back bank is `~front_bank`. Contents are not cleared by reset.
- FSM states: IDLE, LOAD, PENDING.
  - **IDLE:** `wr_ready`=0.
    - `start` → LOAD. `wr_addr`←0, `wr_count`←0.
  - **LOAD:** `wr_ready`=1, `busy`=1.
    - Each cycle with `wr_valid`&`wr_ready`: write `wr_data` to {~front_bank, wr_addr}, then increment `wr_addr` and `wr_count`.
    - The write at `wr_addr`==DEPTH-1 → PENDING. `wr_count`=DEPTH.
    - `start` in LOAD is ignored; it does not restart the load.
    - `vsync` in LOAD has no effect.
  - **PENDING:** `wr_ready`=0, `pending`=1.
    - `vsync` → `front_bank` toggles, state → IDLE.
    - `start` in PENDING is ignored.
- `vsync` in IDLE has no effect. No swap occurs without a completed load.
- Reads always target the front bank, so read and write never touch the same bank.
- `wr_addr` never wraps. The FSM leaves LOAD on the write at DEPTH-1. `wr_count` saturates at DEPTH by construction.

## Timing
- Reset values: `wr_ready`=0, `busy`=0, `pending`=0, `front_bank`=0, `q`=0, `wr_count`=0. State is IDLE.
- Reset mid-LOAD or mid-PENDING abandons the load. The partial back-bank data stays in memory but is never made visible.
- **Read latency:** `q` at edge N+1 equals mem[{front_bank sampled at edge N+1, `address` sampled at edge N+1}].
  - `q` is registered; data is valid the cycle after `address`.
- **Swap edge:** the read issued in the `vsync` cycle returns old-bank data. Reads issued from the next cycle onward return new-bank data.
- `wr_ready` is a registered function of state: 1 in the cycle after `start` is sampled, and 0 in the cycle after the final write.
- **Throughput:** 1 pixel/cycle. A full load is DEPTH accepting cycles, with arbitrary `wr_valid` gaps allowed.
- **Simultaneous events:**
  - Final write and `vsync` in the same cycle: enter PENDING, no swap. The swap waits for the next `vsync`.
  - `start` and `vsync` in PENDING: swap only, `start` dropped.
- `wr_data` and `wr_valid` are ignored whenever `wr_ready`=0.

## Test plan
- **Reset defaults:** assert `reset` 2 cycles → all outputs 0, state IDLE; `wr_valid`=1 with no `start` → `wr_ready` stays 0, `wr_count`=0.
- **Full load and swap:**
  - `start`, then stream `wr_data`=i%16 for i=0..1023 continuously → `busy` for 1024 cycles, then `pending`=1, `wr_count`=1024.
  - `vsync` → `front_bank`=1; reading `address`=37 gives `q`=5 the next cycle.
- **Gapped stream:** `wr_valid` toggling 1,0,1,0 during load → `wr_count` increments only on accepted cycles; final contents match the sequence with no skipped or duplicated entries.
- **Swap edge read:**
  - Bank 0 filled with 0x3, bank 1 with 0xA; read `address`=0 every cycle across `vsync`.
  - → `q`=0x3 for the read issued in the `vsync` cycle, `q`=0xA for reads issued after it.
- **Ignored events:**
  - `vsync` during LOAD → `front_bank` unchanged.
  - `start` at `wr_count`=500 → `wr_count` continues to 501, no restart.
  - Final write coincident with `vsync` → `pending`=1, `front_bank` unchanged until the next `vsync`.
- **Reset mid-load:** reset at `wr_count`=700 → IDLE, `front_bank` unchanged; the front-bank read of `address`=10 returns the pre-load value.
